// File: rtl/tree_walker.sv
// Tree-forest inference walker: walks every loaded tree for one sample and
// sums the reached leaf values into a signed 32-bit prediction.
module tree_walker #(
  parameter  int N_TREES   = 128,
  parameter  int TREES_LEN = 256,
  localparam int NB        = $clog2(TREES_LEN),
  localparam int TREE_BITS = $clog2(N_TREES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          sample_idx,
  input  logic [31:0]          n_trees,
  input  logic [31:0]          n_features,
  output logic                 busy,
  output logic                 node_rd_en,
  output logic [TREE_BITS-1:0] node_rd_tree,
  output logic [NB-1:0]        node_rd_node,
  input  logic [63:0]          node_rd_data,
  output logic                 feat_rd_en,
  output logic [31:0]          feat_rd_addr,
  input  logic [31:0]          feat_rd_data,
  output logic                 pred_valid,
  input  logic                 pred_ready,
  output logic [31:0]          pred_data,
  output logic [31:0]          pred_sample,
  output logic                 err
);

  // state      | meaning
  // S_IDLE     | waiting for start
  // S_NODE_REQ | node store read issued for (tree, node)
  // S_NODE_DEC | node word valid: add leaf, fetch feature, or bad-index compare
  // S_FEAT_CMP | feature valid: choose child, advance depth counter
  // S_OUT      | prediction presented until accepted
  typedef enum logic [2:0] {
    S_IDLE, S_NODE_REQ, S_NODE_DEC, S_FEAT_CMP, S_OUT
  } state_t;

  state_t                state_q, state_d;
  logic [31:0]           sample_q, sample_d;
  logic [31:0]           nfeat_q, nfeat_d;
  logic [31:0]           base_q, base_d;
  logic [31:0]           acc_q, acc_d;
  logic                  err_q, err_d;
  logic [TREE_BITS-1:0]  tree_q, tree_d;
  logic [TREE_BITS-1:0]  last_tree_q, last_tree_d;
  logic [NB-1:0]         node_q, node_d;
  logic [NB:0]           steps_q, steps_d;
  logic signed [31:0]    thr_q, thr_d;
  logic [NB-1:0]         left_q, left_d;
  logic [NB-1:0]         right_q, right_d;

  logic [31:0]           ntr_clamped;
  logic signed [31:0]    dec_value;
  logic [7:0]            dec_feat;
  logic [NB-1:0]         dec_left, dec_right;
  logic                  dec_leaf, dec_feat_ok, depth_hit, tree_done;
  logic                  unused_bits;

  assign unused_bits = ^node_rd_data[7:1];

  always_comb begin
    ntr_clamped = (n_trees > 32'(N_TREES)) ? 32'(N_TREES) : n_trees;
    dec_value   = node_rd_data[63:32];
    dec_right   = node_rd_data[24 +: NB];
    dec_left    = node_rd_data[16 +: NB];
    dec_feat    = node_rd_data[15:8];
    dec_leaf    = node_rd_data[0];
    dec_feat_ok = ({24'b0, dec_feat} < nfeat_q);
    // this step would be the TREES_LEN-th descent of the current tree
    depth_hit   = (steps_q == (NB+1)'(TREES_LEN - 1));
  end

  always_comb begin
    state_d      = state_q;
    sample_d     = sample_q;
    nfeat_d      = nfeat_q;
    base_d       = base_q;
    acc_d        = acc_q;
    err_d        = err_q;
    tree_d       = tree_q;
    last_tree_d  = last_tree_q;
    node_d       = node_q;
    steps_d      = steps_q;
    thr_d        = thr_q;
    left_d       = left_q;
    right_d      = right_q;
    node_rd_en   = 1'b0;
    feat_rd_en   = 1'b0;
    feat_rd_addr = '0;
    tree_done    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sample_d    = sample_idx;
          nfeat_d     = n_features;
          base_d      = sample_idx * n_features;
          acc_d       = '0;
          err_d       = 1'b0;
          tree_d      = '0;
          node_d      = '0;
          steps_d     = '0;
          last_tree_d = TREE_BITS'(ntr_clamped - 32'd1);
          state_d     = (ntr_clamped == 32'd0) ? S_OUT : S_NODE_REQ;
        end
      end
      S_NODE_REQ: begin
        node_rd_en = 1'b1;
        state_d    = S_NODE_DEC;
      end
      S_NODE_DEC: begin
        if (dec_leaf) begin
          acc_d     = acc_q + dec_value;
          tree_done = 1'b1;
        end else if (dec_feat_ok) begin
          feat_rd_en   = 1'b1;
          feat_rd_addr = base_q + {24'b0, dec_feat};
          thr_d        = dec_value;
          left_d       = dec_left;
          right_d      = dec_right;
          state_d      = S_FEAT_CMP;
        end else begin
          // Out-of-range feature reads as 0; still counts as a descent so a
          // bad self-loop cannot hang the walk.
          err_d = 1'b1;
          if (depth_hit) begin
            tree_done = 1'b1;
          end else begin
            node_d  = (32'sd0 < dec_value) ? dec_left : dec_right;
            steps_d = steps_q + (NB+1)'(1);
            state_d = S_NODE_REQ;
          end
        end
      end
      S_FEAT_CMP: begin
        if (depth_hit) begin
          err_d     = 1'b1;
          tree_done = 1'b1;
        end else begin
          node_d  = ($signed(feat_rd_data) < thr_q) ? left_q : right_q;
          steps_d = steps_q + (NB+1)'(1);
          state_d = S_NODE_REQ;
        end
      end
      S_OUT: begin
        if (pred_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (tree_done) begin
      if (tree_q == last_tree_q) begin
        state_d = S_OUT;
      end else begin
        tree_d  = tree_q + TREE_BITS'(1);
        node_d  = '0;
        steps_d = '0;
        state_d = S_NODE_REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sample_q    <= '0;
      nfeat_q     <= '0;
      base_q      <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      tree_q      <= '0;
      last_tree_q <= '0;
      node_q      <= '0;
      steps_q     <= '0;
      thr_q       <= '0;
      left_q      <= '0;
      right_q     <= '0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      nfeat_q     <= nfeat_d;
      base_q      <= base_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      tree_q      <= tree_d;
      last_tree_q <= last_tree_d;
      node_q      <= node_d;
      steps_q     <= steps_d;
      thr_q       <= thr_d;
      left_q      <= left_d;
      right_q     <= right_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign pred_valid   = (state_q == S_OUT);
  assign pred_data    = acc_q;
  assign pred_sample  = sample_q;
  assign err          = err_q;
  assign node_rd_tree = tree_q;
  assign node_rd_node = node_q;

endmodule

// File: doc/tree_walker.md
Name: tree_walker

Overview:
- Inference engine for the tree-forest accelerator. It walks every tree of the loaded forest for one sample and accumulates the leaf values into a 32-bit prediction.
- It sits in the accelerator's COMPUTE stage. It consumes the node store and feature store filled by the DMA-read stage, and hands one prediction per sample to the predictions buffer that feeds the DMA-write stage.
- The control FSM issues one start per sample.

Parameters:
N_TREES, 128, max trees in forest; node store depth per tree
TREES_LEN, 256, nodes per tree; node indices are $clog2(TREES_LEN) bits (NB)
TREE_BITS, $clog2(N_TREES), width of tree index

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; latch sample_idx/n_trees/n_features; ignored while busy
sample_idx  in  32  sample to infer
n_trees  in  32  trees to evaluate; values above N_TREES are clamped to N_TREES
n_features  in  32  features per sample
busy  out  1  high in every state except IDLE
node_rd_en  out  1  node store read strobe
node_rd_tree  out  TREE_BITS  tree index of read
node_rd_node  out  NB  node index of read
node_rd_data  in  64  node word, valid the cycle after node_rd_en
feat_rd_en  out  1  feature store read strobe
feat_rd_addr  out  32  sample_idx*n_features + feature index
feat_rd_data  in  32  signed feature, valid the cycle after feat_rd_en
pred_valid  out  1  prediction available
pred_ready  in  1  consumer accepts prediction
pred_data  out  32  signed sum of leaf values
pred_sample  out  32  sample_idx the prediction belongs to
err  out  1  sticky fault flag; cleared on accepted start

Behaviour:
- Node word format:
  - [63:32] signed threshold (internal node) or signed leaf value (leaf).
  - [31:24] right child, [23:16] left child. Only the low NB bits are used.
  - [15:8] feature index. [0] leaf flag. Other bits ignored.
- Reset: state IDLE. All outputs 0. Accumulator, tree counter, node index and step counter 0. A reset mid-walk abandons the sample with no pred_valid.
- Start in IDLE:
  - Register the inputs.
  - Compute base = sample_idx*n_features (32-bit, truncating).
  - Clear acc, err, tree=0, node=0, steps=0.
  - If the clamped n_trees==0 → OUT with pred_data=0; otherwise → NODE_REQ.
- NODE_REQ (1 cycle): node_rd_en=1 with current tree/node → NODE_DEC.
- NODE_DEC (node_rd_data valid):
  - Leaf: acc += leaf value (32-bit wrap). Then go to NEXT_TREE handling.
  - Internal, feature index < n_features: feat_rd_en=1, feat_rd_addr=base+index, hold threshold and children → FEAT_CMP.
  - Internal, feature index ≥ n_features: set err, take feature=0, compare in the same cycle, update node → NODE_REQ. No feature read is issued.
- FEAT_CMP: compare signed feat_rd_data < threshold → node=left, else node=right. steps++ → NODE_REQ.
- Depth guard: when steps reaches TREES_LEN in FEAT_CMP, set err, add nothing for this tree, go to NEXT_TREE handling.
- NEXT_TREE handling (no extra cycle):
  - If tree == n_trees−1 → OUT.
  - Otherwise tree++, node=0, steps=0 → NODE_REQ.
- Latency:
  - Leaf step: 2 cycles. Internal-node step: 3 cycles.
  - Start-to-pred_valid = 1 + Σ over trees (3·internal_nodes_visited + 2).
  - n_trees=0 gives 1 cycle.
- OUT:
  - pred_valid=1; pred_data=acc and pred_sample are held stable.
  - On pred_valid && pred_ready, the next cycle has pred_valid=0 and state IDLE.
  - Backpressure is indefinite; nothing changes while waiting.
- Strobes node_rd_en and feat_rd_en are never high simultaneously and are never high outside NODE_REQ/NODE_DEC.
- A start arriving in the same cycle as the OUT handshake is ignored because busy is still high.

Test Plan:
- Single tree, root leaf value 7, n_trees=1, start → pred_valid 3 cycles after start, pred_data=7, err=0.
- Depth-2 tree, root feat 1 thr 10: feature[1]=5 → left leaf 100; feature[1]=10 → right leaf −3. n_features=4, sample_idx=2 → feat_rd_addr=9; preds 100 and −3; latency 6 cycles.
- n_trees=3, every root leaf with values 1,2,0x7FFFFFFF → pred_data=0x80000002 (wrap); n_trees=200 clamped to 128 trees walked.
- n_trees=0 → pred_valid on cycle after start, pred_data=0, no node/feature reads.
- Root feature index 9 with n_features=4 → err=1, no feat_rd_en, child chosen using feature 0 vs threshold. Self-loop node (both children 0, non-leaf) → err=1 after TREES_LEN steps, tree contributes 0, walk completes.
- Hold pred_ready=0 for 20 cycles then pulse; assert rst mid-walk → outputs stable during stall, single accept. After rst: busy=0, pred_valid=0, and the next start works normally.
